iommu_field_hs: RTL and testbench

Parametrised IOMMU register field with a software-to-hardware commit handshake, for control fields such as enable bits and pointer registers. A software write to such a field takes effect only after the hardware side acknowledges it. The block supports mixed per-bit access: RW bits go through the handshake, W1C bits are set by hardware events and cleared by software, and HW-owned bits take direct hardware updates. It exposes a busy flag and a timeout abort. It sits in the register file between the SW register interface and the IOMMU functional units.

---
 rtl/iommu_field_hs.sv | 180 ++++++++++++++++++
 tb/tb_iommu_field_hs.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_field_hs.sv
// -----------------------------------------------------------------------------
// iommu_field_hs
//
// IOMMU register field with a software-to-hardware commit handshake.
// A SW write to the RW bits is staged and offered to the hardware side on
// req_o/req_data_o. It lands in q only once ack_i is seen. If no ack arrives
// within TIMEOUT cycles, the staged value is abandoned.
//
// Per-bit access types:
//   RW_MASK  - SW written through the handshake (or directly if HANDSHAKE=0)
//   W1C_MASK - set by hw_set, cleared by SW writing 1 (set wins over clear)
//   HW_MASK  - overwritten by d when de is high
//   others   - read-only, hold RESVAL
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   we, wd          SW write strobe / data
//   de, d           HW write enable / data for HW_MASK bits
//   hw_set          HW event bits for W1C_MASK bits
//   req_o           commit request (high throughout PEND)
//   req_data_o      staged RW value, stable while req_o is high
//   ack_i           HW accepts the staged value
//   q, qs           committed value (HW / SW read ports)
//   qe              one-cycle pulse when RW bits are committed
//   busy_o          handshake in progress
//   timeout_o       one-cycle pulse when a pending commit is abandoned
//   wr_drop_o       one-cycle pulse when an RW write arrives while busy
// -----------------------------------------------------------------------------
module iommu_field_hs #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    RESVAL     = '0,
    parameter logic [DATA_WIDTH-1:0]    RW_MASK    = '1,
    parameter logic [DATA_WIDTH-1:0]    W1C_MASK   = '0,
    parameter logic [DATA_WIDTH-1:0]    HW_MASK    = '0,
    parameter bit                       HANDSHAKE  = 1'b1,
    parameter int unsigned              TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  de,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [DATA_WIDTH-1:0] hw_set,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    input  logic                  ack_i,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] qs,
    output logic                  qe,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  wr_drop_o
);

    // A zero TIMEOUT still needs a legal (unused) counter width.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value in the TIMEOUT-th PEND cycle (counter starts at 0).
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [DATA_WIDTH-1:0] RO_MASK = ~(RW_MASK | W1C_MASK | HW_MASK);
    localparam bit HAS_RW = (RW_MASK != '0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_q;
    logic [DATA_WIDTH-1:0]   w_q_next;
    logic [DATA_WIDTH-1:0]   r_req_data;
    logic [DATA_WIDTH-1:0]   w_req_data_next;
    logic [DATA_WIDTH-1:0]   w_commit_data;
    logic                    w_commit;
    logic                    w_timeout;
    logic                    w_drop;
    logic                    r_qe;
    logic                    r_timeout;
    logic                    r_wr_drop;

    // ------------------------------------------------------------------
    // Handshake FSM: next state, staging and event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_req_data_next = r_req_data;
        w_commit_data   = r_req_data;
        w_commit        = 1'b0;
        w_timeout       = 1'b0;
        w_drop          = 1'b0;

        if (HANDSHAKE) begin
            unique case (r_state)
                ST_IDLE: begin
                    // Every write starts a handshake, even an unchanged value.
                    if (we && HAS_RW) begin
                        w_state_next    = ST_PEND;
                        w_cnt_next      = '0;
                        w_req_data_next = wd & RW_MASK;
                    end
                end
                ST_PEND: begin
                    w_drop = we && HAS_RW;
                    // Ack is checked first so it wins in the last PEND cycle.
                    if (ack_i) begin
                        w_commit     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                        w_timeout       = 1'b1;
                        w_state_next    = ST_IDLE;
                        w_req_data_next = '0;
                    end else if (TIMEOUT != 0) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end else begin
            // Direct mode: the write itself is the commit.
            w_commit      = we && HAS_RW;
            w_commit_data = wd & RW_MASK;
        end
    end

    // ------------------------------------------------------------------
    // Field value update. Ordering gives the priorities:
    // HW write first, then W1C (so hw_set beats de), then commit on top.
    // ------------------------------------------------------------------
    always_comb begin
        w_q_next = r_q;
        if (de) begin
            w_q_next = (w_q_next & ~HW_MASK) | (d & HW_MASK);
        end
        w_q_next = (w_q_next & ~(W1C_MASK & wd & {DATA_WIDTH{we}}))
                 | (hw_set & W1C_MASK);
        if (w_commit) begin
            w_q_next = (w_q_next & ~RW_MASK) | (w_commit_data & RW_MASK);
        end
        w_q_next = (w_q_next & ~RO_MASK) | (RESVAL & RO_MASK);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_q        <= RESVAL;
            r_req_data <= '0;
            r_qe       <= 1'b0;
            r_timeout  <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_q        <= w_q_next;
            r_req_data <= w_req_data_next;
            r_qe       <= w_commit;
            r_timeout  <= w_timeout;
            r_wr_drop  <= w_drop;
        end
    end

    assign q          = r_q;
    assign qs         = r_q;
    assign qe         = r_qe;
    assign req_data_o = r_req_data;
    assign req_o      = HANDSHAKE && (r_state == ST_PEND);
    assign busy_o     = HANDSHAKE && (r_state == ST_PEND);
    assign timeout_o  = r_timeout;
    assign wr_drop_o  = r_wr_drop;

endmodule

// File: tb/tb_iommu_field_hs.sv
// -----------------------------------------------------------------------------
// tb_iommu_field_hs
//
// Directed bench for iommu_field_hs. Main instance: 32-bit field, RESVAL=0,
// RW bits 0xFFFF_00FF, W1C bit 8, HW bits 0xFF, TIMEOUT=4, handshake on.
// Bits 9..15 are read-only. A second 8-bit instance runs without the
// handshake (RESVAL=0xA0, RW bits 0x0F, TIMEOUT=0).
// Inputs are driven 1 time unit after a rising edge; outputs are checked
// at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_iommu_field_hs;

    logic        clk;
    logic        rst_n;

    // Main instance signals
    logic        we;
    logic [31:0] wd;
    logic        de;
    logic [31:0] d;
    logic [31:0] hw_set;
    logic        ack;
    logic        req;
    logic [31:0] req_data;
    logic [31:0] q;
    logic [31:0] qs;
    logic        qe;
    logic        busy;
    logic        timeout;
    logic        wr_drop;

    // Direct-mode instance signals
    logic        we2;
    logic [7:0]  wd2;
    logic        req2;
    logic [7:0]  req_data2;
    logic [7:0]  q2;
    logic [7:0]  qs2;
    logic        qe2;
    logic        busy2;
    logic        timeout2;
    logic        wr_drop2;

    int n_checks = 0;
    int n_err    = 0;

    iommu_field_hs #(
        .DATA_WIDTH (32),
        .RESVAL     (32'h0000_0000),
        .RW_MASK    (32'hFFFF_00FF),
        .W1C_MASK   (32'h0000_0100),
        .HW_MASK    (32'h0000_00FF),
        .HANDSHAKE  (1'b1),
        .TIMEOUT    (4)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we         (we),
        .wd         (wd),
        .de         (de),
        .d          (d),
        .hw_set     (hw_set),
        .req_o      (req),
        .req_data_o (req_data),
        .ack_i      (ack),
        .q          (q),
        .qs         (qs),
        .qe         (qe),
        .busy_o     (busy),
        .timeout_o  (timeout),
        .wr_drop_o  (wr_drop)
    );

    iommu_field_hs #(
        .DATA_WIDTH (8),
        .RESVAL     (8'hA0),
        .RW_MASK    (8'h0F),
        .W1C_MASK   (8'h00),
        .HW_MASK    (8'h00),
        .HANDSHAKE  (1'b0),
        .TIMEOUT    (0)
    ) u_direct (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we         (we2),
        .wd         (wd2),
        .de         (1'b0),
        .d          (8'h00),
        .hw_set     (8'h00),
        .req_o      (req2),
        .req_data_o (req_data2),
        .ack_i      (1'b0),
        .q          (q2),
        .qs         (qs2),
        .qe         (qe2),
        .busy_o     (busy2),
        .timeout_o  (timeout2),
        .wr_drop_o  (wr_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        wd     = '0;
        de     = 1'b0;
        d      = '0;
        hw_set = '0;
        ack    = 1'b0;
        we2    = 1'b0;
        wd2    = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_q",        q,        32'h0);
        chk("rst_req",      req,      0);
        chk("rst_req_data", req_data, 32'h0);
        chk("rst_busy",     busy,     0);
        chk("rst_qe",       qe,       0);
        chk("rst_timeout",  timeout,  0);
        chk("rst_wr_drop",  wr_drop,  0);
        chk("rst_q2",       q2,       32'hA0);
        rst_n = 1'b1;
        tick();

        // ---------------- direct mode (second instance) ----------------
        we2 = 1'b1; wd2 = 8'hFF;
        tick();
        we2 = 1'b0;
        chk("dir_q",    q2,    32'hAF);
        chk("dir_qs",   qs2,   32'hAF);
        chk("dir_qe",   qe2,   1);
        chk("dir_busy", busy2, 0);
        chk("dir_req",  req2,  0);
        tick();
        chk("dir_qe_end", qe2, 0);

        // ---------------- basic commit ----------------
        we = 1'b1; wd = 32'hA5A5_0001;
        tick();
        we = 1'b0;
        chk("bc_req",      req,      1);
        chk("bc_busy",     busy,     1);
        chk("bc_req_data", req_data, 32'hA5A5_0001);
        chk("bc_q_hold",   q,        32'h0);
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("bc_q",    q,    32'hA5A5_0001);
        chk("bc_qs",   qs,   32'hA5A5_0001);
        chk("bc_qe",   qe,   1);
        chk("bc_busy_done", busy, 0);
        tick();
        chk("bc_qe_end", qe, 0);

        // ---------------- timeout: no ack ----------------
        we = 1'b1; wd = 32'h0000_0055;
        tick();
        we = 1'b0;
        chk("to_busy_c1", busy, 1);
        tick();
        tick();
        tick();
        chk("to_busy_c4",    busy,    1);
        chk("to_timeout_c4", timeout, 0);
        tick();
        chk("to_busy_c5",     busy,     0);
        chk("to_timeout",     timeout,  1);
        chk("to_q_unchanged", q,        32'hA5A5_0001);
        chk("to_req_data",    req_data, 32'h0);
        chk("to_qe",          qe,       0);
        tick();
        chk("to_timeout_end", timeout, 0);

        // ---------------- timeout: ack in the last cycle ----------------
        we = 1'b1; wd = 32'h0000_0066;
        tick();
        we = 1'b0;
        tick();
        tick();
        tick();
        chk("ta_busy_c4", busy, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ta_q",       q,       32'h0000_0066);
        chk("ta_qe",      qe,      1);
        chk("ta_timeout", timeout, 0);
        chk("ta_busy",    busy,    0);
        tick();
        chk("ta_timeout_after", timeout, 0);

        // ---------------- write dropped while busy ----------------
        we = 1'b1; wd = 32'h0000_0001;
        tick();
        wd = 32'h0000_0002;
        tick();
        we = 1'b0;
        chk("dr_wr_drop",  wr_drop,  1);
        chk("dr_req_data", req_data, 32'h0000_0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("dr_q",       q,       32'h0000_0001);
        chk("dr_qe",      qe,      1);
        chk("dr_wr_drop_end", wr_drop, 0);

        // ---------------- W1C set / clear race ----------------
        hw_set = 32'h0000_0100;
        tick();
        hw_set = 32'h0;
        chk("w1c_set", q, 32'h0000_0101);
        we = 1'b1; wd = 32'h0000_0100; hw_set = 32'h0000_0100;
        tick();
        we = 1'b0; hw_set = 32'h0;
        chk("w1c_race_q",    q,        32'h0000_0101);
        chk("w1c_race_busy", busy,     1);
        chk("w1c_race_stg",  req_data, 32'h0);
        // Clear while busy: W1C part applies, RW part is dropped.
        we = 1'b1; wd = 32'h0000_0100;
        tick();
        we = 1'b0;
        chk("w1c_clear_q",  q,       32'h0000_0001);
        chk("w1c_clear_dr", wr_drop, 1);
        tick();
        tick();
        tick();
        chk("w1c_timeout",   timeout, 1);
        chk("w1c_timeout_q", q,       32'h0000_0001);

        // ---------------- HW write vs commit ----------------
        we = 1'b1; wd = 32'h0000_0022;
        tick();
        we = 1'b0;
        de = 1'b1; d = 32'h0000_0011; ack = 1'b1;
        tick();
        de = 1'b0; ack = 1'b0;
        chk("col_q",  q,  32'h0000_0022);
        chk("col_qe", qe, 1);
        de = 1'b1; d = 32'hFFFF_FF11;
        tick();
        de = 1'b0;
        chk("hw_q",  q,    32'h0000_0011);
        chk("hw_qe", qe,   0);

        // ---------------- read-only bits, hw_set on non-W1C bits ----------------
        we = 1'b1; wd = 32'h0000_FE33; hw_set = 32'h0000_0600;
        tick();
        we = 1'b0; hw_set = 32'h0;
        chk("ro_req_data", req_data, 32'h0000_0033);
        chk("ro_q_hold",   q,        32'h0000_0011);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ro_q", q, 32'h0000_0033);

        // ---------------- ack in IDLE is ignored ----------------
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_qe", qe, 0);
        chk("idle_ack_q",  q,  32'h0000_0033);

        // ---------------- reset mid-PEND ----------------
        we = 1'b1; wd = 32'h0000_0044;
        tick();
        we = 1'b0;
        chk("mr_busy_pre", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("mr_q",        q,        32'h0);
        chk("mr_busy",     busy,     0);
        chk("mr_req",      req,      0);
        chk("mr_req_data", req_data, 32'h0);
        chk("mr_qe",       qe,       0);
        tick();
        rst_n = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mr_ack_q",       q,       32'h0);
        chk("mr_ack_qe",      qe,      0);
        chk("mr_ack_busy",    busy,    0);
        chk("mr_ack_timeout", timeout, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
